// File: rtl/line_drawer.sv
// Bresenham line rasteriser streaming pixels to a framebuffer.
// Off-screen pixels are stepped over without waiting for pixel_ready.
module line_drawer #(
    parameter  int HOR_ACTIVE_PIXELS = 640,
    parameter  int VER_ACTIVE_PIXELS = 480,
    localparam int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [Y_WIDTH-1:0] y2,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_write,
    input  logic               pixel_ready
);
    localparam int E_WIDTH = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 3;
    localparam logic [X_WIDTH:0] X_LIMIT = (X_WIDTH+1)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH:0] Y_LIMIT = (Y_WIDTH+1)'(VER_ACTIVE_PIXELS);

    // IDLE is all-zero so cleared flops come up idle
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] INIT = 2'd1;
    localparam logic [1:0] DRAW = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [X_WIDTH-1:0]        cur_x_q, cur_x_d;
    logic [Y_WIDTH-1:0]        cur_y_q, cur_y_d;
    logic [X_WIDTH-1:0]        end_x_q, end_x_d;
    logic [Y_WIDTH-1:0]        end_y_q, end_y_d;
    logic signed [E_WIDTH-1:0] dx_q, dx_d;
    logic signed [E_WIDTH-1:0] dy_q, dy_d;
    logic signed [E_WIDTH-1:0] err_q, err_d;
    logic                      sx_neg_q, sx_neg_d;
    logic                      sy_neg_q, sy_neg_d;

    logic signed [E_WIDTH-1:0] cx_s, cy_s, ex_s, ey_s;
    logic signed [E_WIDTH-1:0] dx_abs, dy_neg, e2;
    logic                      step_x, step_y;
    logic                      at_end, visible, advance;

    assign cx_s = signed'(E_WIDTH'(cur_x_q));
    assign cy_s = signed'(E_WIDTH'(cur_y_q));
    assign ex_s = signed'(E_WIDTH'(end_x_q));
    assign ey_s = signed'(E_WIDTH'(end_y_q));

    assign dx_abs = (ex_s > cx_s) ? (ex_s - cx_s) : (cx_s - ex_s);
    assign dy_neg = (ey_s > cy_s) ? (cy_s - ey_s) : (ey_s - cy_s);

    assign e2     = err_q <<< 1;
    assign step_x = (e2 >= dy_q);
    assign step_y = (e2 <= dx_q);

    assign at_end  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
    assign visible = ({1'b0, cur_x_q} < X_LIMIT) && ({1'b0, cur_y_q} < Y_LIMIT);
    assign advance = (state_q == DRAW) && (!visible || pixel_ready);

    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        end_x_d  = end_x_q;
        end_y_d  = end_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_x_d = x1;
                    cur_y_d = y1;
                    end_x_d = x2;
                    end_y_d = y2;
                    state_d = INIT;
                end
            end
            INIT: begin
                dx_d     = dx_abs;
                dy_d     = dy_neg;
                err_d    = dx_abs + dy_neg;
                sx_neg_d = !(cur_x_q < end_x_q);
                sy_neg_d = !(cur_y_q < end_y_q);
                state_d  = DRAW;
            end
            DRAW: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = IDLE;
                    end else begin
                        // both axis steps use the pre-update error term
                        if (step_x) begin
                            cur_x_d = sx_neg_q ? cur_x_q - 1'b1 : cur_x_q + 1'b1;
                        end
                        if (step_y) begin
                            cur_y_d = sy_neg_q ? cur_y_q - 1'b1 : cur_y_q + 1'b1;
                        end
                        err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            end_x_q  <= '0;
            end_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            end_x_q  <= end_x_d;
            end_y_q  <= end_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign pixel_write = (state_q == DRAW) && visible;
    assign pixel_x     = cur_x_q;
    assign pixel_y     = cur_y_q;

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: table of lines with hand-worked pixels,
// plus stall, off-screen, back-to-back and mid-line reset sequences.
module tb_line_drawer;
    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ready;
    logic [XW-1:0] x1, x2, pixel_x;
    logic [YW-1:0] y1, y2, pixel_y;
    logic          pixel_write;
    logic          pixel_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    line_drawer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ready       (ready),
        .x1          (x1),
        .x2          (x2),
        .y1          (y1),
        .y2          (y2),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_write (pixel_write),
        .pixel_ready (pixel_ready)
    );

    typedef struct {
        int x1; int y1; int x2; int y2;
        int nwr; int busy; int stall_at; int stall_len;
    } vec_t;

    typedef struct {
        int x; int y;
    } pix_t;

    vec_t vecs[9];
    pix_t exp_q[$];
    int   exp_idx = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int y);
        pix_t p;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
    endtask

    // Samples at posedge+1 and drives the inputs for the next edge.
    task automatic draw(input vec_t v, input string tag);
        int busy = 0, nwr = 0, first = -1, hold = 0, held = 0, cyc;
        bit done = 0;
        pix_t e;
        check({tag, "_ready_at_start"}, int'(ready), 1);
        x1 = XW'(v.x1);
        y1 = YW'(v.y1);
        x2 = XW'(v.x2);
        y2 = YW'(v.y2);
        start = 1'b1;
        tick();
        start = 1'b0;
        x1 = '1;
        y1 = '1;
        x2 = '0;
        y2 = '0;
        cyc = 1;
        while (!done) begin
            if (cyc > 200) begin
                check({tag, "_timeout"}, 0, 1);
                done = 1;
            end else if (ready) begin
                check({tag, "_end_write_low"}, int'(pixel_write), 0);
                done = 1;
            end else begin
                busy++;
                start = 1'b0;
                pixel_ready = 1'b0;
                if (pixel_write) begin
                    if (first < 0) first = cyc;
                    if (nwr < v.nwr) begin
                        e = exp_q[exp_idx + nwr];
                        check({tag, "_px"}, int'(pixel_x), e.x);
                        check({tag, "_py"}, int'(pixel_y), e.y);
                    end else begin
                        check({tag, "_extra_write"}, 1, 0);
                    end
                    if (nwr == v.stall_at) hold++;
                    if (nwr == v.stall_at && held < v.stall_len) begin
                        held++;
                        start = 1'b1;
                        x1 = 10'd100;
                        y1 = 9'd100;
                        x2 = 10'd200;
                        y2 = 9'd200;
                    end else begin
                        pixel_ready = 1'b1;
                        nwr++;
                    end
                end
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_busy"}, busy, v.busy);
        check({tag, "_nwr"}, nwr, v.nwr);
        check({tag, "_first_cyc"}, first, 2);
        if (v.stall_len > 0) check({tag, "_hold"}, hold, v.stall_len + 1);
        exp_idx += v.nwr;
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 240, 7, 240, 8, 9, -1, 0};
        for (int i = 0; i < 8; i++) push(i, 240);
        vecs[1] = '{0, 0, 2, 5, 6, 7, -1, 0};
        push(0, 0); push(0, 1); push(1, 2); push(1, 3); push(2, 4); push(2, 5);
        vecs[2] = '{2, 5, 0, 0, 6, 7, -1, 0};
        push(2, 5); push(2, 4); push(1, 3); push(1, 2); push(0, 1); push(0, 0);
        vecs[3] = '{5, 5, 5, 5, 1, 2, -1, 0};
        push(5, 5);
        vecs[4] = '{635, 0, 645, 0, 5, 12, -1, 0};
        for (int i = 635; i < 640; i++) push(i, 0);
        vecs[5] = '{0, 0, 5, 2, 6, 7, -1, 0};
        push(0, 0); push(1, 0); push(2, 1); push(3, 1); push(4, 2); push(5, 2);
        vecs[6] = '{3, 1, 0, 4, 4, 5, -1, 0};
        push(3, 1); push(2, 2); push(1, 3); push(0, 4);
        vecs[7] = '{10, 10, 13, 10, 4, 8, 1, 3};
        for (int i = 10; i < 14; i++) push(i, 10);
        vecs[8] = '{1, 1, 2, 2, 2, 3, -1, 0};
        push(1, 1); push(2, 2);

        rst = 1'b1;
        start = 1'b1;
        x1 = 10'd5; y1 = 9'd5; x2 = 10'd9; y2 = 9'd9;
        pixel_ready = 1'b1;
        tick();
        tick();
        check("rst_ready", int'(ready), 1);
        check("rst_write", int'(pixel_write), 0);
        check("rst_px", int'(pixel_x), 0);
        check("rst_py", int'(pixel_y), 0);
        rst = 1'b0;
        start = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            draw(vecs[i], $sformatf("vec%0d", i));
        end

        // abort (0,0)->(20,0) while its third pixel is presented
        x1 = 10'd0; y1 = 9'd0; x2 = 10'd20; y2 = 9'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (pixel_write) begin
                if (n == 2) break;
                n++;
            end
            pixel_ready = 1'b1;
            tick();
        end
        check("abort_third_px", int'(pixel_x), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", int'(ready), 1);
        check("abort_write", int'(pixel_write), 0);
        check("abort_px", int'(pixel_x), 0);
        tick();
        check("abort_quiet", int'(pixel_write), 0);
        draw(vecs[8], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
